// File: rtl/mem_access_unit_if.sv
// Data-memory port between the memory access unit (master) and the data cache (slave).
interface mem_access_unit_if;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_addr;
  logic [3:0]  data_mbe;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_resp;

  // Strobe-until-response handshake: the master raises data_read or data_write
  // with addr/mbe/wdata stable and keeps them until data_resp, which the slave
  // pulses for exactly one cycle; strobes drop in the following cycle.
  modport master (
    output data_read, data_write, data_addr, data_mbe, data_wdata,
    input  data_rdata, data_resp
  );

  modport slave (
    input  data_read, data_write, data_addr, data_mbe, data_wdata,
    output data_rdata, data_resp
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-side end of the control-word interface: runs the data-memory handshake,
// generates byte lanes for stores and extends load data for the regfile mux.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  store_type,
  input  logic [2:0]  load_funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [1:0]  dbg_state,
  mem_access_unit_if.master dmem
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) + 1 : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic TO_EN = (TIMEOUT_CYCLES > 0);

  state_t      state_q;
  logic        rd_q, wr_q;
  logic        done_q, err_q;
  logic [31:0] rdata_q;
  logic [31:0] daddr_q, dwdata_q;
  logic [3:0]  mbe_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [1:0]  st_q;
  logic [CW-1:0] cnt_q;

  logic        is_half_d, is_byte_d, misaligned_d;
  logic [3:0]  mbe_d;
  logic [31:0] dwdata_d;
  logic [31:0] load_ext_d;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        timeout_hit;

  // Request decode; a write takes priority when both strobes are set.
  always_comb begin
    is_half_d    = 1'b0;
    is_byte_d    = 1'b0;
    misaligned_d = 1'b0;
    mbe_d        = 4'b1111;
    dwdata_d     = wdata;
    if (mem_write) begin
      is_half_d = (store_type == 2'b01);
      is_byte_d = (store_type == 2'b10);
    end else begin
      is_half_d = (load_funct3[1:0] == 2'b01);
      is_byte_d = (load_funct3[1:0] == 2'b00);
    end
    if (is_half_d)      misaligned_d = addr[0];
    else if (!is_byte_d) misaligned_d = (addr[1:0] != 2'b00);
    if (mem_write && is_byte_d) begin
      mbe_d    = 4'b0001 << addr[1:0];
      dwdata_d = {4{wdata[7:0]}};
    end else if (mem_write && is_half_d) begin
      mbe_d    = 4'b0011 << addr[1:0];
      dwdata_d = {2{wdata[15:0]}};
    end
  end

  always_comb begin
    ld_byte    = dmem.data_rdata[8*off_q +: 8];
    ld_half    = dmem.data_rdata[16*off_q[1] +: 16];
    load_ext_d = dmem.data_rdata;
    case (f3_q)
      3'b000:  load_ext_d = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_ext_d = {24'd0, ld_byte};
      3'b001:  load_ext_d = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_ext_d = {16'd0, ld_half};
      default: load_ext_d = dmem.data_rdata;
    endcase
  end

  assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      daddr_q  <= '0;
      mbe_q    <= '0;
      dwdata_q <= '0;
      off_q    <= '0;
      f3_q     <= '0;
      st_q     <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          if (mem_read || mem_write) begin
            off_q   <= addr[1:0];
            f3_q    <= load_funct3;
            st_q    <= store_type;
            cnt_q   <= '0;
            rdata_q <= '0;
            if (misaligned_d) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q  <= S_ACCESS;
              daddr_q  <= {addr[31:2], 2'b00};
              mbe_q    <= mbe_d;
              dwdata_q <= dwdata_d;
              rd_q     <= ~mem_write;
              wr_q     <= mem_write;
            end
          end
        end
        S_ACCESS: begin
          if (dmem.data_resp) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b0;
            state_q <= S_DONE;
            if (rd_q) rdata_q <= load_ext_d;
          end else if (timeout_hit) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else if (TO_EN && (cnt_q != {CW{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stall           = (mem_read | mem_write) & ~done_q;
  assign done            = done_q;
  assign err             = err_q;
  assign rdata           = rdata_q;
  assign dbg_state       = state_q;
  assign dmem.data_read  = rd_q;
  assign dmem.data_write = wr_q;
  assign dmem.data_addr  = daddr_q;
  assign dmem.data_mbe   = mbe_q;
  assign dmem.data_wdata = dwdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: unit A has an 8-cycle timeout, unit B none.
module tb_mem_access_unit;

  logic clk;
  logic rst;

  logic        a_rd, a_wr, b_rd, b_wr;
  logic [1:0]  a_st, b_st;
  logic [2:0]  a_f3, b_f3;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_stall, a_done, a_err, b_stall, b_done, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic [1:0]  a_dbg, b_dbg;

  mem_access_unit_if if_a ();
  mem_access_unit_if if_b ();

  mem_access_unit #(.TIMEOUT_CYCLES(8)) dut_a (
    .clk(clk), .rst(rst), .mem_read(a_rd), .mem_write(a_wr), .store_type(a_st),
    .load_funct3(a_f3), .addr(a_addr), .wdata(a_wdata), .stall(a_stall),
    .done(a_done), .err(a_err), .rdata(a_rdata), .dbg_state(a_dbg), .dmem(if_a)
  );

  mem_access_unit #(.TIMEOUT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .mem_read(b_rd), .mem_write(b_wr), .store_type(b_st),
    .load_funct3(b_f3), .addr(b_addr), .wdata(b_wdata), .stall(b_stall),
    .done(b_done), .err(b_err), .rdata(b_rdata), .dbg_state(b_dbg), .dmem(if_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // {check_rdata, err, rdata}
  logic [33:0] exp_a_q[$];
  logic [33:0] exp_b_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // driver tasks
  task automatic set_req(input bit sel, input logic rd, input logic wr, input logic [1:0] st,
                         input logic [2:0] f3, input logic [31:0] ad, input logic [31:0] wd);
    if (sel) begin
      b_rd = rd; b_wr = wr; b_st = st; b_f3 = f3; b_addr = ad; b_wdata = wd;
    end else begin
      a_rd = rd; a_wr = wr; a_st = st; a_f3 = f3; a_addr = ad; a_wdata = wd;
    end
  endtask

  task automatic set_mem(input bit sel, input logic resp, input logic [31:0] d);
    if (sel) begin
      if_b.data_resp = resp; if_b.data_rdata = d;
    end else begin
      if_a.data_resp = resp; if_a.data_rdata = d;
    end
  endtask

  // One access: request in cycle 0, data_resp in cycle resp_at (0 = never),
  // done expected in cycle exp_done.
  task automatic run(input string nm, input bit sel, input logic rd, input logic wr,
                     input logic [1:0] st, input logic [2:0] f3, input logic [31:0] ad,
                     input logic [31:0] wd, input logic [31:0] mrd, input int resp_at,
                     input logic exp_rs, input logic exp_ws, input logic [31:0] exp_addr,
                     input logic [3:0] exp_mbe, input logic [31:0] exp_wd,
                     input logic [31:0] exp_rdata, input logic exp_err, input int exp_done);
    logic s_done, s_rd, s_wr, s_stall;
    logic [31:0] s_addr, s_wd;
    logic [3:0]  s_mbe;
    bit seen;
    @(negedge clk);
    set_req(sel, rd, wr, st, f3, ad, wd);
    if (sel) exp_b_q.push_back({rd & ~wr, exp_err, exp_rdata});
    else     exp_a_q.push_back({rd & ~wr, exp_err, exp_rdata});
    seen = 1'b0;
    for (int c = 1; c <= 60 && !seen; c++) begin
      @(negedge clk);
      if (sel) begin
        s_done = b_done; s_rd = if_b.data_read; s_wr = if_b.data_write; s_stall = b_stall;
        s_addr = if_b.data_addr; s_mbe = if_b.data_mbe; s_wd = if_b.data_wdata;
      end else begin
        s_done = a_done; s_rd = if_a.data_read; s_wr = if_a.data_write; s_stall = a_stall;
        s_addr = if_a.data_addr; s_mbe = if_a.data_mbe; s_wd = if_a.data_wdata;
      end
      check({nm, " strobes"}, {30'd0, s_rd, s_wr}, (c < exp_done) ? {30'd0, exp_rs, exp_ws} : 32'd0);
      check({nm, " done"}, {31'd0, s_done}, {31'd0, c == exp_done});
      check({nm, " stall"}, {31'd0, s_stall}, {31'd0, c != exp_done});
      if (c == 1 && (exp_rs || exp_ws)) begin
        check({nm, " data_addr"}, s_addr, exp_addr);
        check({nm, " data_mbe"}, {28'd0, s_mbe}, {28'd0, exp_mbe});
        if (exp_ws) check({nm, " data_wdata"}, s_wd, exp_wd);
      end
      if (s_done) begin
        seen = 1'b1;
        set_req(sel, 1'b0, 1'b0, 2'b00, 3'b000, 32'd0, 32'd0);
      end
      set_mem(sel, c == resp_at, mrd);
    end
    set_mem(sel, 1'b0, 32'd0);
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s timeout: got no done want done at cycle %0d", nm, exp_done);
    end
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    logic [33:0] e;
    if (a_done) begin
      if (exp_a_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected done on unit A: got done=1 want 0");
      end else begin
        e = exp_a_q.pop_front();
        check("A err", {31'd0, a_err}, {31'd0, e[32]});
        if (e[33]) check("A rdata", a_rdata, e[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    logic [33:0] e;
    if (b_done) begin
      if (exp_b_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected done on unit B: got done=1 want 0");
      end else begin
        e = exp_b_q.pop_front();
        check("B err", {31'd0, b_err}, {31'd0, e[32]});
        if (e[33]) check("B rdata", b_rdata, e[31:0]);
      end
    end
  end

  initial begin
    rst = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 32'd0, 32'd0);
    set_req(1'b1, 1'b0, 1'b0, 2'b00, 3'b000, 32'd0, 32'd0);
    set_mem(1'b0, 1'b0, 32'd0);
    set_mem(1'b1, 1'b0, 32'd0);
    repeat (3) @(negedge clk);
    check("reset strobes", {30'd0, if_a.data_read, if_a.data_write}, 32'd0);
    check("reset done/err", {30'd0, a_done, a_err}, 32'd0);
    check("reset rdata", a_rdata, 32'd0);
    check("reset data_addr", if_a.data_addr, 32'd0);
    check("reset mbe/state", {26'd0, if_a.data_mbe, a_dbg}, 32'd0);
    check("reset data_wdata", if_a.data_wdata, 32'd0);
    rst = 1'b1;

    //  name        sel rd wr st     f3      addr          wdata         mrd           resp rs ws exp_addr      mbe      exp_wd        exp_rdata     err done
    run("sw",        0, 1, 1'b1, 2'b00, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'd0,        4, 0, 1, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'd0,        0, 5);
    run("sw type11", 0, 0, 1'b1, 2'b11, 3'b000, 32'h0000_0104, 32'h0102_0304, 32'd0,        1, 0, 1, 32'h0000_0104, 4'b1111, 32'h0102_0304, 32'd0,        0, 2);
    run("sb",        0, 0, 1'b1, 2'b10, 3'b000, 32'h0000_0203, 32'h0000_00A5, 32'd0,        1, 0, 1, 32'h0000_0200, 4'b1000, 32'hA5A5_A5A5, 32'd0,        0, 2);
    run("sh",        0, 0, 1'b1, 2'b01, 3'b000, 32'h0000_0202, 32'h1234_ABCD, 32'd0,        2, 0, 1, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 32'd0,        0, 3);
    run("lb",        0, 1, 1'b0, 2'b00, 3'b000, 32'h0000_0301, 32'd0,        32'h1234_80FF, 1, 1, 0, 32'h0000_0300, 4'b1111, 32'd0,        32'hFFFF_FF80, 0, 2);
    run("lbu",       0, 1, 1'b0, 2'b00, 3'b100, 32'h0000_0301, 32'd0,        32'h1234_80FF, 1, 1, 0, 32'h0000_0300, 4'b1111, 32'd0,        32'h0000_0080, 0, 2);
    run("lh hi",     0, 1, 1'b0, 2'b00, 3'b001, 32'h0000_0302, 32'd0,        32'h1234_80FF, 1, 1, 0, 32'h0000_0300, 4'b1111, 32'd0,        32'h0000_1234, 0, 2);
    run("lh lo",     0, 1, 1'b0, 2'b00, 3'b001, 32'h0000_0300, 32'd0,        32'h1234_80FF, 2, 1, 0, 32'h0000_0300, 4'b1111, 32'd0,        32'hFFFF_80FF, 0, 3);
    run("lhu",       0, 1, 1'b0, 2'b00, 3'b101, 32'h0000_0300, 32'd0,        32'h1234_80FF, 1, 1, 0, 32'h0000_0300, 4'b1111, 32'd0,        32'h0000_80FF, 0, 2);
    run("lb b3",     0, 1, 1'b0, 2'b00, 3'b000, 32'h0000_0403, 32'd0,        32'h7F00_0000, 1, 1, 0, 32'h0000_0400, 4'b1111, 32'd0,        32'h0000_007F, 0, 2);
    run("lw",        0, 1, 1'b0, 2'b00, 3'b010, 32'h0000_0304, 32'd0,        32'hCAFE_F00D, 3, 1, 0, 32'h0000_0304, 4'b1111, 32'd0,        32'hCAFE_F00D, 0, 4);
    run("lw misal",  0, 1, 1'b0, 2'b00, 3'b010, 32'h0000_0402, 32'd0,        32'hFFFF_FFFF, 0, 0, 0, 32'd0,        4'b0000, 32'd0,        32'd0,        1, 1);
    run("sh misal",  0, 0, 1'b1, 2'b01, 3'b000, 32'h0000_0401, 32'h0000_BEEF, 32'd0,        0, 0, 0, 32'd0,        4'b0000, 32'd0,        32'd0,        1, 1);
    run("lw timeout",0, 1, 1'b0, 2'b00, 3'b010, 32'h0000_0600, 32'd0,        32'd0,        0, 1, 0, 32'h0000_0600, 4'b1111, 32'd0,        32'd0,        1, 9);
    run("rd+wr",     0, 1, 1'b1, 2'b00, 3'b010, 32'h0000_0700, 32'h1122_3344, 32'd0,        1, 0, 1, 32'h0000_0700, 4'b1111, 32'h1122_3344, 32'd0,        0, 2);
    run("lw slow",   1, 1, 1'b0, 2'b00, 3'b010, 32'h0000_0900, 32'd0,        32'h55AA_55AA, 20, 1, 0, 32'h0000_0900, 4'b1111, 32'd0,       32'h55AA_55AA, 0, 21);

    // reset in the middle of an access, with a late response during reset
    @(negedge clk);
    set_req(1'b0, 1'b1, 1'b0, 2'b00, 3'b010, 32'h0000_0500, 32'd0);
    repeat (2) @(negedge clk);
    check("pre-reset read strobe", {31'd0, if_a.data_read}, 32'd1);
    rst = 1'b0;
    #1;
    check("mid-reset strobes", {30'd0, if_a.data_read, if_a.data_write}, 32'd0);
    set_mem(1'b0, 1'b1, 32'h0BAD_0BAD);
    @(negedge clk);
    set_mem(1'b0, 1'b0, 32'd0);
    check("mid-reset done/state", {29'd0, a_done, a_dbg}, 32'd0);
    set_req(1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run("post-reset lw", 0, 1, 1'b0, 2'b00, 3'b010, 32'h0000_0800, 32'd0, 32'h8765_4321, 2, 1, 0, 32'h0000_0800, 4'b1111, 32'd0, 32'h8765_4321, 0, 3);

    repeat (3) @(negedge clk);
    check("A queue drained", exp_a_q.size(), 32'd0);
    check("B queue drained", exp_b_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
